// File: rtl/execute_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide share one accumulator and one control FSM.
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            busy_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ({(2*XLEN){1'b0}} - v) : v;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [4:0]          rd_addr_q, rd_addr_d;

    logic                is_div, sa, sb, div0, ovf;
    logic [XLEN-1:0]     abs_a, abs_b, spec_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [XLEN:0]       rem_sh, div_diff;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, fix_res;

    assign is_div = op_q[2];
    assign sa     = (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a_q[XLEN-1];
    assign sb     = (op_q inside {OP_MULH, OP_DIV, OP_REM}) && b_q[XLEN-1];
    assign abs_a  = cneg_x(a_q, sa);
    assign abs_b  = cneg_x(b_q, sb);
    assign div0   = is_div && (b_q == '0);
    assign ovf    = (op_q inside {OP_DIV, OP_REM}) && (a_q == {1'b1, {(XLEN-1){1'b0}}})
                    && (b_q == '1);
    assign spec_res = div0 ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);

    // Multiply step: the multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: the shifted remainder needs XLEN+1 bits before the trial subtract.
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = cneg_2x(acc_q, neg_q);
    assign quo  = cneg_x(acc_q[XLEN-1:0], neg_q);
    assign rem  = cneg_x(acc_q[2*XLEN-1:XLEN], neg_q);

    always_comb begin
        fix_res = '0;
        if (spec_q) begin
            fix_res = acc_q[XLEN-1:0];
        end else begin
            unique case (op_q)
                OP_MUL:                       fix_res = prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              fix_res = quo;
                OP_REM, OP_REMU:              fix_res = rem;
                default:                      fix_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        spec_d    = spec_q;
        rd_data_d = rd_data_q;
        rd_addr_d = rd_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    op_d      = op_i;
                    a_d       = rs1_data_i;
                    b_d       = rs2_data_i;
                    rd_addr_d = rd_addr_i;
                    spec_d    = 1'b0;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                a_d    = abs_a;
                b_d    = abs_b;
                cnt_d  = CNT_W'(XLEN);
                neg_d  = (op_q == OP_REM) ? sa : (sa ^ sb);
                spec_d = div0 || ovf;
                if (div0 || ovf) begin
                    acc_d   = {{XLEN{1'b0}}, spec_res};
                    state_d = S_FIXUP;
                end else begin
                    acc_d   = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                rd_data_d = fix_res;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            spec_q    <= 1'b0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            spec_q    <= spec_d;
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign valid_o   = (state_q == S_DONE);
    assign busy_o    = (state_q != S_IDLE);
    assign rd_data_o = rd_data_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: results, latency, backpressure, flush and reset.
module tb_execute_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    execute_muldiv #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .rd_data_o  (rd_data_o),
        .rd_addr_o  (rd_addr_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready_o), 64'(1));
        check({tag, "_valid"}, 64'(valid_o), 64'(0));
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_data"}, 64'(rd_data_o), 64'(0));
        check({tag, "_addr"}, 64'(rd_addr_o), 64'(0));
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input string name);
        @(negedge clk_i);
        check({name, "_ready_pre"}, 64'(ready_o), 64'(1));
        valid_i    = 1'b1;
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = tag;
        @(posedge clk_i);
        #1;
        valid_i    = 1'b0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        check({name, "_busy"}, 64'(busy_o), 64'(1));
    endtask

    task automatic wait_valid(input int exp_lat, input string name);
        int lat = 0;
        while (valid_o !== 1'b1 && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic consume(input string name);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check({name, "_valid_drop"}, 64'(valid_o), 64'(0));
        check({name, "_ready_back"}, 64'(ready_o), 64'(1));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int lat,
                          input string name);
        issue(op, a, b, tag, name);
        wait_valid(lat, name);
        check({name, "_data"}, 64'(rd_data_o), 64'(exp));
        check({name, "_tag"}, 64'(rd_addr_o), 64'(tag));
        consume(name);
    endtask

    initial begin
        int seen;
        #1 rst_ni = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 34, "mul");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 34, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 34, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 34, "remu");
        run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 2, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 2, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2, "rem_ovf");

        // Backpressure in DONE.
        issue(3'd5, 32'd100, 32'd7, 5'd3, "bp");
        wait_valid(34, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_hold_valid", 64'(valid_o), 64'(1));
            check("bp_hold_data", 64'(rd_data_o), 64'(14));
            check("bp_hold_tag", 64'(rd_addr_o), 64'(3));
            check("bp_hold_ready", 64'(ready_o), 64'(0));
        end
        consume("bp");
        run_op(3'd0, 32'd6, 32'd7, 5'd14, 32'd42, 34, "after_bp");

        // Flush coinciding with a request in IDLE.
        @(negedge clk_i);
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_idle_busy", 64'(busy_o), 64'(0));
        check("flush_idle_ready", 64'(ready_o), 64'(1));

        // Flush wins over ready_i in DONE.
        issue(3'd0, 32'd3, 32'd5, 5'd15, "flush_done");
        wait_valid(34, "flush_done");
        @(negedge clk_i);
        ready_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        flush_i = 1'b0;
        check("flush_done_valid", 64'(valid_o), 64'(0));
        check("flush_done_ready", 64'(ready_o), 64'(1));

        // Flush at CALC cycle 10.
        issue(3'd0, 32'd7, 32'd5, 5'd16, "flush_calc");
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_calc_busy", 64'(busy_o), 64'(0));
        check("flush_calc_ready", 64'(ready_o), 64'(1));
        check("flush_calc_valid", 64'(valid_o), 64'(0));
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) seen = 1;
        end
        check("flush_calc_no_pulse", 64'(seen), 64'(0));
        run_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 34, "after_flush");

        // Asynchronous reset in the middle of CALC.
        issue(3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 5'd21, "rst_mid");
        repeat (15) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, 34, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
